// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter multiplexing NREQ producers onto a single FIFO write port.
// One owner at a time, up to BURST words per grant, stalls while the FIFO is full.
module fifo_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  fifo_full,
    output logic                  fifo_cs,
    output logic                  fifo_we,
    output logic [WIDTH-1:0]      fifo_data,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state, state_nx;
    logic [NREQ-1:0]            grant_nx;
    logic [PW-1:0]              rr_ptr, rr_nx, gidx;
    logic [CW-1:0]              cnt, cnt_nx;
    logic                       busy_nx;
    logic                       owner_req, xfer, found;
    logic [NREQ-1:0]            pick_oh;
    int                         pos;
    logic [NREQ-1:0][WIDTH-1:0] lane_data;

    assign lane_data = req_data;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) gidx = PW'(i);
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_oh = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[pos]) begin
                pick_oh[pos] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign owner_req = |(grant & req);
    assign xfer      = (state == BUSY) & owner_req & ~fifo_full & ~reset;
    assign fifo_we   = xfer;
    assign ack       = grant & {NREQ{xfer}};
    assign fifo_data = xfer ? lane_data[gidx] : '0;
    assign fifo_cs   = busy & ~reset;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        cnt_nx   = cnt;
        busy_nx  = busy;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nx = pick_oh;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // A dropped request ends the grant even while the FIFO is full.
                if (!owner_req || (!fifo_full && cnt == CW'(BURST - 1))) begin
                    grant_nx = '0;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                    rr_nx    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                end else if (!fifo_full) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= rr_nx;
            cnt    <= cnt_nx;
            busy   <= busy_nx;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector table, then producer-driven
// sequences whose written words are matched against an expected-word queue.
module tb_fifo_write_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic           fifo_cs, fifo_we, busy;
    logic [W-1:0]   fifo_data;
    logic [N-1:0]   ack, grant;

    fifo_write_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .fifo_cs(fifo_cs), .fifo_we(fifo_we),
        .fifo_data(fifo_data), .ack(ack), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    int         n[N];
    logic [7:0] wd[N];

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic       full;
        logic [3:0] eg;
        logic       eb;
        logic       ewe;
        logic       ecs;
        logic [3:0] eack;
        logic [7:0] edata;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle driven by the producer models; written words go to the queue check.
    task automatic tick(input logic rst, input logic full);
        @(negedge clk);
        reset     = rst;
        fifo_full = full;
        for (int i = 0; i < N; i++) begin
            req[i]            = (n[i] > 0);
            req_data[i*W +: W] = wd[i];
        end
        #1;
        chk("ack_vs_grant", 32'(ack), fifo_we ? 32'(grant) : 32'd0);
        if (fifo_we) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got write %0h expected none", fifo_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("fifo_data", 32'(fifo_data), 32'(e));
            end
        end
        for (int i = 0; i < N; i++)
            if (ack[i]) begin
                wd[i]++;
                n[i]--;
            end
    endtask

    task automatic cyc(input logic full, input logic [3:0] eg, input logic ewe, input string tag);
        tick(1'b0, full);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_we"}, 32'(fifo_we), 32'(ewe));
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            n[i]  = 0;
            wd[i] = '0;
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        //            rst  req     full  grant   busy we  cs  ack     data
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 8'h00};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 8'h00};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 8'h00};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1, 1, 1, 4'b0001, 8'h11};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1, 0, 1, 4'b0000, 8'h00};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1, 0, 1, 4'b0000, 8'h00};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 8'h00};
        tbl[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 8'h00};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1, 1, 1, 4'b0100, 8'h33};
        tbl[9]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1, 0, 0, 4'b0000, 8'h00};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 8'h00};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1, 1, 1, 4'b0001, 8'h11};

        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            reset     = tbl[r].rst;
            req       = tbl[r].rq;
            fifo_full = tbl[r].full;
            req_data  = 32'h44332211;
            #1;
            chk($sformatf("tbl%0d_grant", r), 32'(grant), 32'(tbl[r].eg));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].eb));
            chk($sformatf("tbl%0d_we", r), 32'(fifo_we), 32'(tbl[r].ewe));
            chk($sformatf("tbl%0d_cs", r), 32'(fifo_cs), 32'(tbl[r].ecs));
            chk($sformatf("tbl%0d_ack", r), 32'(ack), 32'(tbl[r].eack));
            chk($sformatf("tbl%0d_data", r), 32'(fifo_data), 32'(tbl[r].edata));
        end

        // Single producer, six words: burst of four, one idle cycle, then two more.
        do_reset();
        n[2] = 6;
        wd[2] = 8'h10;
        for (int k = 0; k < 6; k++) sb.push_back(8'(8'h10 + k));
        cyc(0, 4'b0000, 0, "t2c0");
        for (int k = 0; k < 4; k++) cyc(0, 4'b0100, 1, "t2burst");
        cyc(0, 4'b0000, 0, "t2gap");
        cyc(0, 4'b0100, 1, "t2c6");
        cyc(0, 4'b0100, 1, "t2c7");
        cyc(0, 4'b0100, 0, "t2drop");
        cyc(0, 4'b0000, 0, "t2idle");
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // All four requesting: rotation 0,1,2,3,0 with 4-on/1-off write pattern.
        do_reset();
        for (int i = 0; i < N; i++) begin
            n[i]  = 100;
            wd[i] = 8'(i * 8'h40);
        end
        for (int g = 0; g < 5; g++)
            for (int k = 0; k < 4; k++)
                sb.push_back(8'((g % 4) * 8'h40 + (g / 4) * 4 + k));
        for (int c = 0; c < 25; c++)
            cyc(0, (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4)), (c % 5 != 0), "t3");
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Full stall mid-burst: grant held, remaining two words after full drops.
        do_reset();
        n[0] = 10;
        wd[0] = 8'hA0;
        for (int k = 0; k < 4; k++) sb.push_back(8'(8'hA0 + k));
        cyc(0, 4'b0000, 0, "t4c0");
        cyc(0, 4'b0001, 1, "t4c1");
        cyc(0, 4'b0001, 1, "t4c2");
        for (int k = 0; k < 3; k++) cyc(1, 4'b0001, 0, "t4full");
        cyc(0, 4'b0001, 1, "t4c6");
        cyc(0, 4'b0001, 1, "t4c7");
        cyc(0, 4'b0000, 0, "t4rel");
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Early drop by owner 1 with requester 3 waiting: pointer moves to 2, 3 wins.
        do_reset();
        n[0] = 1;
        wd[0] = 8'h05;
        sb.push_back(8'h05);
        cyc(0, 4'b0000, 0, "t5c0");
        cyc(0, 4'b0001, 1, "t5c1");
        cyc(0, 4'b0001, 0, "t5c2");
        n[1] = 2;
        wd[1] = 8'h50;
        n[3] = 5;
        wd[3] = 8'h70;
        sb.push_back(8'h50);
        sb.push_back(8'h51);
        sb.push_back(8'h70);
        cyc(0, 4'b0000, 0, "t5c3");
        cyc(0, 4'b0010, 1, "t5c4");
        cyc(0, 4'b0010, 1, "t5c5");
        cyc(0, 4'b0010, 0, "t5drop");
        cyc(0, 4'b0000, 0, "t5idle");
        cyc(0, 4'b1000, 1, "t5next");
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
